i2c_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-byte `i2c_controller` instance between up to `NUM_REQ` sensor readers on the same I2C bus. Each requester presents a one-byte register read or write. The block issues it to the controller, waits for completion, and returns the result with a done/error pulse. It also supervises the controller with a watchdog and resets it if a transaction hangs.

---
 rtl/i2c_arb_pkg.sv | 34 +++
 rtl/i2c_bus_arbiter_rr_picker.sv | 34 +++
 rtl/i2c_bus_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types, default timing constants and packed-bus helpers for the
// I2C bus arbiter.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_RECOVER    = 3'd4,
    S_COMPLETE   = 3'd5
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_START_MAX      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 120_000;
  localparam int DEF_RECOVER_CYCLES = 4;

  // Widest packed bus the helpers accept: 8 requesters x 8 bits.
  localparam int BUS_W = 64;

  // Extract field number idx (each 'width' bits wide, width <= 8) from a
  // packed per-requester bus; the result is right-aligned and zero-filled.
  function automatic logic [7:0] field_slice(input logic [BUS_W-1:0] bus,
                                             input int unsigned     width,
                                             input int unsigned     idx);
    logic [BUS_W-1:0] shifted;
    logic [7:0]       mask;
    shifted = bus >> (idx * width);
    mask    = 8'hFF >> (32'd8 - width);
    return shifted[7:0] & mask;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// Round-robin picker: finds the first asserted request strictly after the
// pointer position, wrapping around, and reports it one-hot and as an index.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos_s;

  // Rotating priority search; the first hit wins and later hits are ignored.
  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    pos_s  = '0;
    for (int i = 1; i <= N; i++) begin
      pos_s = IW'((32'(ptr) + 32'(i)) % N);
      if (!any && req[pos_s]) begin
        any           = 1'b1;
        onehot[pos_s] = 1'b1;
        idx           = pos_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter / sequencer sharing one single-byte I2C controller
// among NUM_REQ requesters, with start and busy watchdogs that reset a hung
// controller and report the failure back to the owning requester.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int START_MAX      = DEF_START_MAX,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_dev_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 req_error,
  output logic [7:0]           rdata,
  output logic                 m_enable,
  output logic                 m_read_write,
  output logic [6:0]           m_device_address,
  output logic [7:0]           m_register_address,
  output logic [7:0]           m_mosi_data,
  input  logic [7:0]           m_miso_data,
  input  logic                 m_busy,
  output logic                 m_reset_n,
  output logic [7:0]           fault_count
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One counter serves all three waits, so size it for the longest one.
  localparam int CNT_TOP = (TIMEOUT_CYCLES > START_MAX)
                           ? ((TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES)
                           : ((START_MAX > RECOVER_CYCLES) ? START_MAX : RECOVER_CYCLES);
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] START_LAST   = CW'(START_MAX - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYCLES - 1);

  arb_state_t         state_r, state_n;
  logic [IW-1:0]      ptr_r, ptr_n;
  logic [CW-1:0]      cnt_r, cnt_n;
  logic               err_r, err_n;
  logic               rw_r, rw_n;
  logic [6:0]         dev_r, dev_n;
  logic [7:0]         reg_addr_r, reg_addr_n;
  logic [7:0]         wdata_r, wdata_n;
  logic [NUM_REQ-1:0] grant_r, grant_n;
  logic [NUM_REQ-1:0] done_r, done_n;
  logic               req_error_r, req_error_n;
  logic [7:0]         rdata_r, rdata_n;
  logic               m_enable_r, m_enable_n;
  logic               m_reset_n_r, m_reset_n_n;
  logic [7:0]         fault_r, fault_n;

  logic               pick_any_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IW-1:0]      pick_idx_s;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_r),
    .any    (pick_any_s),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Next-state and next-output logic; everything visible outside is registered.
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    cnt_n       = cnt_r;
    err_n       = err_r;
    rw_n        = rw_r;
    dev_n       = dev_r;
    reg_addr_n  = reg_addr_r;
    wdata_n     = wdata_r;
    grant_n     = grant_r;
    done_n      = '0;
    req_error_n = 1'b0;
    rdata_n     = 8'h00;
    m_enable_n  = 1'b0;
    m_reset_n_n = 1'b1;
    fault_n     = fault_r;
    case (state_r)
      S_IDLE: begin
        // A busy controller here belongs to someone else; wait it out.
        if (!m_busy && pick_any_s) begin
          ptr_n      = pick_idx_s;
          rw_n       = req_rw[pick_idx_s];
          dev_n      = 7'(field_slice(BUS_W'(req_dev_addr), 32'd7, 32'(pick_idx_s)));
          reg_addr_n = field_slice(BUS_W'(req_reg_addr), 32'd8, 32'(pick_idx_s));
          wdata_n    = field_slice(BUS_W'(req_wdata), 32'd8, 32'(pick_idx_s));
          grant_n    = pick_onehot_s;
          m_enable_n = 1'b1;
          err_n      = 1'b0;
          state_n    = S_ISSUE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (m_busy) begin
          cnt_n   = '0;
          state_n = S_WAIT_DONE;
        end else if (cnt_r == START_LAST) begin
          cnt_n       = '0;
          err_n       = 1'b1;
          m_reset_n_n = 1'b0;
          state_n     = S_RECOVER;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!m_busy) begin
          done_n      = grant_r;
          req_error_n = err_r;
          rdata_n     = rw_r ? m_miso_data : 8'h00;
          state_n     = S_COMPLETE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          cnt_n       = '0;
          err_n       = 1'b1;
          m_reset_n_n = 1'b0;
          state_n     = S_RECOVER;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      S_RECOVER: begin
        // Controller reset is held low for exactly RECOVER_CYCLES cycles.
        if (cnt_r == RECOVER_LAST) begin
          done_n      = grant_r;
          req_error_n = err_r;
          fault_n     = (fault_r == 8'hFF) ? fault_r : fault_r + 8'd1;
          state_n     = S_COMPLETE;
        end else begin
          cnt_n       = cnt_r + CW'(1);
          m_reset_n_n = 1'b0;
        end
      end
      S_COMPLETE: begin
        grant_n = '0;
        state_n = S_IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= IW'(NUM_REQ - 1);
      cnt_r       <= '0;
      err_r       <= 1'b0;
      rw_r        <= 1'b0;
      dev_r       <= 7'h00;
      reg_addr_r  <= 8'h00;
      wdata_r     <= 8'h00;
      grant_r     <= '0;
      done_r      <= '0;
      req_error_r <= 1'b0;
      rdata_r     <= 8'h00;
      m_enable_r  <= 1'b0;
      m_reset_n_r <= 1'b1;
      fault_r     <= 8'h00;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      cnt_r       <= cnt_n;
      err_r       <= err_n;
      rw_r        <= rw_n;
      dev_r       <= dev_n;
      reg_addr_r  <= reg_addr_n;
      wdata_r     <= wdata_n;
      grant_r     <= grant_n;
      done_r      <= done_n;
      req_error_r <= req_error_n;
      rdata_r     <= rdata_n;
      m_enable_r  <= m_enable_n;
      m_reset_n_r <= m_reset_n_n;
      fault_r     <= fault_n;
    end
  end

  assign grant              = grant_r;
  assign req_done           = done_r;
  assign req_error          = req_error_r;
  assign rdata              = rdata_r;
  assign m_enable           = m_enable_r;
  assign m_read_write       = rw_r;
  assign m_device_address   = dev_r;
  assign m_register_address = reg_addr_r;
  assign m_mosi_data        = wdata_r;
  // The controller is also held in reset whenever the arbiter is.
  assign m_reset_n          = m_reset_n_r & rst;
  assign fault_count        = fault_r;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed testbench for i2c_bus_arbiter with a small behavioural model of
// the single-byte I2C controller.
module tb_i2c_bus_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_rw;
  logic [27:0]  req_dev_addr;
  logic [31:0]  req_reg_addr;
  logic [31:0]  req_wdata;
  logic [N-1:0] grant;
  logic [N-1:0] req_done;
  logic         req_error;
  logic [7:0]   rdata;
  logic         m_enable;
  logic         m_read_write;
  logic [6:0]   m_device_address;
  logic [7:0]   m_register_address;
  logic [7:0]   m_mosi_data;
  logic [7:0]   m_miso_data;
  logic         m_busy;
  logic         m_reset_n;
  logic [7:0]   fault_count;

  int n_checks;
  int n_errors;

  i2c_bus_arbiter #(
    .NUM_REQ        (N),
    .START_MAX      (16),
    .TIMEOUT_CYCLES (1000),
    .RECOVER_CYCLES (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_rw             (req_rw),
    .req_dev_addr       (req_dev_addr),
    .req_reg_addr       (req_reg_addr),
    .req_wdata          (req_wdata),
    .grant              (grant),
    .req_done           (req_done),
    .req_error          (req_error),
    .rdata              (rdata),
    .m_enable           (m_enable),
    .m_read_write       (m_read_write),
    .m_device_address   (m_device_address),
    .m_register_address (m_register_address),
    .m_mosi_data        (m_mosi_data),
    .m_miso_data        (m_miso_data),
    .m_busy             (m_busy),
    .m_reset_n          (m_reset_n),
    .fault_count        (fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: mode 0 = busy for busy_len cycles, 1 = never starts,
  // 2 = busy stuck until its reset is pulled.
  int         mode;
  int         busy_len;
  int         model_cnt;
  logic       model_busy;
  logic       ext_busy;
  logic [7:0] miso_val;

  assign m_busy      = model_busy | ext_busy;
  assign m_miso_data = miso_val;

  always @(posedge clk or negedge m_reset_n) begin
    if (!m_reset_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (m_enable && !model_busy) begin
      if (mode == 0) begin
        model_busy <= 1'b1;
        model_cnt  <= busy_len - 1;
      end else if (mode == 2) begin
        model_busy <= 1'b1;
      end
    end else if (model_busy && mode == 0) begin
      if (model_cnt == 0) model_busy <= 1'b0;
      else model_cnt <= model_cnt - 1;
    end
  end

  // Monitors.
  int         cyc;
  int         en_cnt;
  int         en_cyc;
  int         rise_cyc;
  int         low_cnt;
  int         done_cnt;
  logic       busy_d;
  logic [6:0] cap_dev;
  logic [7:0] cap_reg;
  logic [7:0] cap_wdata;
  logic       cap_rw;
  int         grant_q[$];

  function automatic int oh2idx(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_enable) begin
      en_cnt    <= en_cnt + 1;
      cap_dev   <= m_device_address;
      cap_reg   <= m_register_address;
      cap_wdata <= m_mosi_data;
      cap_rw    <= m_read_write;
      grant_q.push_back(oh2idx(grant));
    end
    if (|req_done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    busy_d <= m_busy;
    if (m_busy && !busy_d) rise_cyc <= cyc;
    if (m_enable) en_cyc <= cyc;
    if (rst && !m_reset_n) low_cnt <= low_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd);
    req_rw[i]             = rw;
    req_dev_addr[i*7 +: 7] = dev;
    req_reg_addr[i*8 +: 8] = ra;
    req_wdata[i*8 +: 8]    = wd;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for a done pulse; samples outputs in the done cycle.
  task automatic wait_done(input string tag, input int budget, output logic [N-1:0] d,
                           output logic e, output logic [7:0] rd,
                           output logic [N-1:0] g, output int dcyc);
    logic found;
    found = 1'b0;
    d = '0; e = 1'b0; rd = 8'h00; g = '0; dcyc = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (req_done != '0) begin
        found = 1'b1;
        d     = req_done;
        e     = req_error;
        rd    = rdata;
        g     = grant;
        dcyc  = cyc;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  logic [N-1:0] d, g;
  logic         e;
  logic [7:0]   rd;
  int           dcyc, base, q0, low0, dc0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    cyc = 0; en_cnt = 0; en_cyc = 0; rise_cyc = 0; low_cnt = 0; done_cnt = 0;
    busy_d = 1'b0;
    mode = 0; busy_len = 300; ext_busy = 1'b0; miso_val = 8'h00;
    req_valid = '0; req_rw = '0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
    rst = 1'b0;
    do_reset();

    // Reset state.
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_done", 32'(req_done), 32'd0);
    check_eq("rst_enable", 32'(m_enable), 32'd0);
    check_eq("rst_mreset", 32'(m_reset_n), 32'd1);
    check_eq("rst_fault", 32'(fault_count), 32'd0);

    // Single write from requester 0, controller busy 300 cycles.
    base = en_cnt;
    set_req(0, 1'b0, 7'h29, 8'h80, 8'h03);
    req_valid[0] = 1'b1;
    wait_done("wr0", 400, d, e, rd, g, dcyc);
    req_valid[0] = 1'b0;
    check_eq("wr0_done", 32'(d), 32'h1);
    check_eq("wr0_err", 32'(e), 32'd0);
    check_eq("wr0_latency", 32'(dcyc - rise_cyc), 32'd301);
    check_eq("wr0_fields", {8'h00, 1'b0, cap_dev, cap_reg, cap_wdata}, {8'h00, 1'b0, 7'h29, 8'h80, 8'h03});
    check_eq("wr0_rw", 32'(cap_rw), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("wr0_one_enable", 32'(en_cnt - base), 32'd1);

    // Round robin with all four continuously requesting.
    do_reset();
    busy_len = 5;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'(8'h10 + 8'(i)), 8'(i), 8'h00);
    q0 = grant_q.size();
    req_valid = 4'hF;
    for (int k = 0; k < 500 && grant_q.size() < q0 + 5; k++) @(negedge clk);
    req_valid = 4'h0;
    check_eq("rr_count", 32'(grant_q.size() - q0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (grant_q.size() > q0 + i) check_eq($sformatf("rr_order%0d", i), 32'(grant_q[q0 + i]), 32'(i % 4));
    wait_done("rr_tail", 50, d, e, rd, g, dcyc);
    check_eq("rr_tail_done", 32'(d), 32'h1);
    base = en_cnt;
    repeat (10) @(negedge clk);
    check_eq("rr_quiet", 32'(en_cnt - base), 32'd0);

    // Read from requester 2; request fields change after issue.
    busy_len = 20;
    miso_val = 8'hA5;
    base = en_cnt;
    set_req(2, 1'b1, 7'h3C, 8'h94, 8'h00);
    req_valid[2] = 1'b1;
    for (int k = 0; k < 20 && en_cnt == base; k++) @(negedge clk);
    set_req(2, 1'b0, 7'h01, 8'h11, 8'h22);
    wait_done("rd2", 100, d, e, rd, g, dcyc);
    req_valid[2] = 1'b0;
    check_eq("rd2_done", 32'(d), 32'h4);
    check_eq("rd2_grant", 32'(g), 32'h4);
    check_eq("rd2_rdata", 32'(rd), 32'hA5);
    check_eq("rd2_err", 32'(e), 32'd0);
    check_eq("rd2_regaddr_held", 32'(m_register_address), 32'h94);
    check_eq("rd2_rw", 32'(cap_rw), 32'd1);
    @(negedge clk);
    check_eq("rd2_rdata_after", 32'(rdata), 32'h0);

    // Controller never starts: start watchdog, recovery, error done.
    mode = 1;
    miso_val = 8'h5A;
    low0 = low_cnt;
    set_req(1, 1'b1, 7'h10, 8'h20, 8'h55);
    req_valid[1] = 1'b1;
    wait_done("nostart", 100, d, e, rd, g, dcyc);
    req_valid[1] = 1'b0;
    check_eq("nostart_done", 32'(d), 32'h2);
    check_eq("nostart_err", 32'(e), 32'd1);
    check_eq("nostart_rdata", 32'(rd), 32'h0);
    check_eq("nostart_latency", 32'(dcyc - en_cyc), 32'd21);
    check_eq("nostart_rstlow", 32'(low_cnt - low0), 32'd4);
    check_eq("nostart_fault", 32'(fault_count), 32'd1);

    // Busy stuck high: busy watchdog, then queued requester 0 served.
    mode = 2;
    low0 = low_cnt;
    set_req(3, 1'b0, 7'h44, 8'h01, 8'h02);
    set_req(0, 1'b0, 7'h29, 8'h80, 8'h07);
    req_valid[3] = 1'b1;
    req_valid[0] = 1'b1;
    wait_done("stuck", 1200, d, e, rd, g, dcyc);
    mode = 0;
    req_valid[3] = 1'b0;
    check_eq("stuck_done", 32'(d), 32'h8);
    check_eq("stuck_err", 32'(e), 32'd1);
    check_eq("stuck_latency", 32'(dcyc - en_cyc), 32'd1006);
    check_eq("stuck_rstlow", 32'(low_cnt - low0), 32'd4);
    check_eq("stuck_fault", 32'(fault_count), 32'd2);
    wait_done("after", 100, d, e, rd, g, dcyc);
    req_valid[0] = 1'b0;
    check_eq("after_done", 32'(d), 32'h1);
    check_eq("after_err", 32'(e), 32'd0);
    check_eq("after_wdata", 32'(cap_wdata), 32'h07);
    check_eq("after_fault", 32'(fault_count), 32'd2);

    // External owner holds busy: arbitration deferred.
    base = en_cnt;
    ext_busy = 1'b1;
    set_req(1, 1'b0, 7'h11, 8'h33, 8'h44);
    req_valid[1] = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("ext_no_enable", 32'(en_cnt - base), 32'd0);
    check_eq("ext_no_grant", 32'(grant), 32'd0);
    ext_busy = 1'b0;
    wait_done("ext", 100, d, e, rd, g, dcyc);
    req_valid[1] = 1'b0;
    check_eq("ext_done", 32'(d), 32'h2);

    // Reset in the middle of a busy wait: no done pulse afterwards.
    busy_len = 300;
    base = en_cnt;
    set_req(2, 1'b0, 7'h22, 8'h66, 8'h77);
    req_valid[2] = 1'b1;
    for (int k = 0; k < 50 && !m_busy; k++) @(negedge clk);
    check_eq("mid_busy", 32'(m_busy), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_grant", 32'(grant), 32'd0);
    check_eq("mid_enable", 32'(m_enable), 32'd0);
    check_eq("mid_fault", 32'(fault_count), 32'd0);
    check_eq("mid_dev", 32'(m_device_address), 32'd0);
    check_eq("mid_mreset", 32'(m_reset_n), 32'd0);
    dc0 = done_cnt;
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("mid_no_done", 32'(done_cnt - dc0), 32'd0);
    check_eq("mid_mreset_rel", 32'(m_reset_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
